fft_input_loader: RTL and testbench

Collects a serial stream of complex samples into one 8-point frame, places each sample in bit-reversed slot order, and presents the whole frame as a parallel bus to the first butterfly rank of the 8-point FFT. It is the sequential front end of the combinational butterfly network. Data is passed through unmodified; the block only buffers and reorders it. Handshakes are valid/ready on both sides.

---
 rtl/fft_input_loader.sv | 114 +++++++++++
 tb/tb_fft_input_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// ---------------------------------------------------------------------------
// fft_input_loader
//
// Sequential front end of the 8-point FFT. Collects eight serial complex
// samples into a frame buffer, writing sample x[idx] into lane bitrev3(idx),
// and then presents the whole reordered frame as a parallel bus to the first
// butterfly rank. Data is never modified, only buffered and reordered.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream sample valid (in_r / in_i / in_first)
//   in_ready   loader accepts a sample this cycle (LOAD state, not in reset)
//   in_r/in_i  real / imaginary part of the sample, W = 2**N bits
//   in_first   marks x0 of a frame; mid-frame it restarts the frame
//   out_valid  full reordered frame present on out_r / out_i
//   out_ready  downstream consumes the frame
//   out_r/i    8 lanes of W bits, lane k at bits [k*W +: W] = x[bitrev3(k)]
//   sync_err   one-cycle pulse after a partial frame was discarded
// ---------------------------------------------------------------------------
module fft_input_loader #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2**N-1:0]     in_r,
    input  logic [2**N-1:0]     in_i,
    input  logic                in_first,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*2**N-1:0]   out_r,
    output logic [8*2**N-1:0]   out_i,
    output logic                sync_err
);

    localparam int W = 2**N;

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [0:0]   state_reg;
    logic [0:0]   state_next;
    logic [2:0]   idx_reg;
    logic [2:0]   idx_next;
    logic         sync_err_reg;

    logic [W-1:0] lane_r_reg [8];
    logic [W-1:0] lane_i_reg [8];

    logic         accept;
    logic         resync;
    logic [2:0]   wr_lane;

    // in_ready depends only on the state register and reset, never on out_ready.
    assign in_ready  = (state_reg == LOAD) & ~rst;
    assign out_valid = (state_reg == FULL);
    assign sync_err  = sync_err_reg;

    assign accept  = in_valid & in_ready;
    // in_first on a non-zero index abandons the partial frame and restarts at x0.
    assign resync  = accept & in_first & (idx_reg != 3'd0);
    assign wr_lane = resync ? 3'd0 : {idx_reg[0], idx_reg[1], idx_reg[2]};

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (accept) begin
            if (resync) begin
                idx_next = 3'd1;
            end else begin
                idx_next = idx_reg + 3'd1;
                if (idx_reg == 3'd7) begin
                    state_next = FULL;
                end
            end
        end else if ((state_reg == FULL) && out_ready) begin
            state_next = LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= LOAD;
            idx_reg      <= 3'd0;
            sync_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            sync_err_reg <= resync;
        end
    end

    // Each lane register is written only when the current sample maps onto it.
    // The lane registers drive the output bus directly.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_r_reg[gi] <= '0;
                    lane_i_reg[gi] <= '0;
                end else if (accept && (wr_lane == 3'(gi))) begin
                    lane_r_reg[gi] <= in_r;
                    lane_i_reg[gi] <= in_i;
                end
            end

            assign out_r[gi*W +: W] = lane_r_reg[gi];
            assign out_i[gi*W +: W] = lane_i_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_fft_input_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_input_loader
//
// Directed testbench for fft_input_loader (N=3, W=8). Inputs are driven on
// the falling edge; outputs are observed on the falling edge, half a cycle
// after the rising edge that updated them. Expected frames are hand-computed
// constants in bit-reversed lane order.
// ---------------------------------------------------------------------------
module tb_fft_input_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_r;
    logic [7:0]  in_i;
    logic        in_first;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_r;
    logic [63:0] out_i;
    logic        sync_err;

    int compared   = 0;
    int mismatched = 0;

    fft_input_loader #(.N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] i, input logic f);
        in_valid = v;
        in_r     = r;
        in_i     = i;
        in_first = f;
    endtask

    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        compared++; if (sync_err !== 1'b0) begin mismatched++; $display("FAIL reset_sync_err: got %0b want 0", sync_err); end
        compared++; if (out_r !== 64'h0 || out_i !== 64'h0) begin mismatched++; $display("FAIL reset_bus: got r=%h i=%h want 0", out_r, out_i); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_in_ready: got %0b want 1", in_ready); end
        $display("test_reset done");
    endtask

    // x_k = (k+1, -(k+1)); ends with the frame held in FULL.
    task automatic test_basic_frame;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 7) begin
                compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
            end
            drive(1'b1, 8'(k + 1), 8'(-(k + 1)), k == 0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_out_valid: got %0b want 1", out_valid); end
        compared++; if (out_r !== 64'h0804060207030501) begin mismatched++; $display("FAIL basic_out_r: got %h want 0804060207030501", out_r); end
        compared++; if (out_i !== 64'hf8fcfafef9fdfbff) begin mismatched++; $display("FAIL basic_out_i: got %h want f8fcfafef9fdfbff", out_i); end
        $display("test_basic_frame done: r=%h i=%h", out_r, out_i);
    endtask

    task automatic test_backpressure;
        // Next frame's x0 is offered while the current frame is still held.
        drive(1'b1, 8'h11, 8'h21, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready cycle %0d: got %0b want 0", c, in_ready); end
            compared++; if (out_r !== 64'h0804060207030501 || out_i !== 64'hf8fcfafef9fdfbff) begin mismatched++; $display("FAIL bp_bus_stable cycle %0d: got r=%h i=%h", c, out_r, out_i); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_out_valid_fall: got %0b want 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_in_ready_rise: got %0b want 1", in_ready); end
        // x0 (still held) is accepted at the coming edge; follow with x1..x7.
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (k == 7) begin
                compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_early_valid: got %0b want 0", out_valid); end
            end
            drive(1'b1, 8'(8'h11 + k), 8'(8'h21 + k), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_frame2_valid: got %0b want 1", out_valid); end
        compared++; if (out_r !== 64'h1814161217131511) begin mismatched++; $display("FAIL bp_frame2_r: got %h want 1814161217131511", out_r); end
        compared++; if (out_i !== 64'h2824262227232521) begin mismatched++; $display("FAIL bp_frame2_i: got %h want 2824262227232521", out_i); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_consume: got %0b want 0", out_valid); end
        $display("test_backpressure done");
    endtask

    task automatic test_resync;
        // j=0..2: partial frame, j=3: in_first restart (0x55,0x66), j=4..10: x1..x7.
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            if (j == 1) begin
                compared++; if (sync_err !== 1'b0) begin mismatched++; $display("FAIL resync_no_err_start: got %0b want 0", sync_err); end
            end
            if (j == 4) begin
                compared++; if (sync_err !== 1'b1) begin mismatched++; $display("FAIL resync_pulse: got %0b want 1", sync_err); end
            end
            if (j == 5) begin
                compared++; if (sync_err !== 1'b0) begin mismatched++; $display("FAIL resync_pulse_width: got %0b want 0", sync_err); end
            end
            if (j == 10) begin
                compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL resync_early_valid: got %0b want 0", out_valid); end
            end
            if (j < 3)       drive(1'b1, 8'(8'hA0 + j), 8'(8'hB0 + j), j == 0);
            else if (j == 3) drive(1'b1, 8'h55, 8'h66, 1'b1);
            else             drive(1'b1, 8'(8'hC0 + j - 3), 8'(8'hD0 + j - 3), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL resync_valid: got %0b want 1", out_valid); end
        compared++; if (out_r !== 64'hC7C3C5C1C6C2C455) begin mismatched++; $display("FAIL resync_out_r: got %h want c7c3c5c1c6c2c455", out_r); end
        compared++; if (out_i !== 64'hD7D3D5D1D6D2D466) begin mismatched++; $display("FAIL resync_out_i: got %h want d7d3d5d1d6d2d466", out_i); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_resync done");
    endtask

    task automatic test_gapped;
        int  k = 0;
        int  cycles = 0;
        bit  pending = 0;
        while (k < 8 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (pending) begin k++; pending = 0; end
            if (k < 8) begin
                compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL gap_early_valid k=%0d: got %0b want 0", k, out_valid); end
                if ($urandom_range(0, 1) == 1) begin
                    drive(1'b1, 8'(8'h30 + k), 8'(8'h40 + k), k == 0);
                    pending = 1;
                end else begin
                    drive(1'b0, 8'hEE, 8'hEE, 1'b1);
                end
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        compared++; if (k != 8) begin mismatched++; $display("FAIL gap_timeout: got %0d accepts want 8", k); end
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL gap_valid: got %0b want 1", out_valid); end
        compared++; if (out_r !== 64'h3733353136323430) begin mismatched++; $display("FAIL gap_out_r: got %h want 3733353136323430", out_r); end
        compared++; if (out_i !== 64'h4743454146424440) begin mismatched++; $display("FAIL gap_out_i: got %h want 4743454146424440", out_i); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_gapped done in %0d cycles", cycles);
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, 8'(8'h91 + k), 8'(8'h81 + k), k == 0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_load_ctrl: got rdy=%0b vld=%0b want 0 0", in_ready, out_valid); end
        compared++; if (out_r !== 64'h0 || out_i !== 64'h0) begin mismatched++; $display("FAIL rstmid_load_bus: got r=%h i=%h want 0", out_r, out_i); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, 8'(8'h01 + k), 8'(8'h01 + k), k == 0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL rstmid_full_reached: got %0b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_full_ctrl: got rdy=%0b vld=%0b want 0 0", in_ready, out_valid); end
        compared++; if (out_r !== 64'h0 || out_i !== 64'h0) begin mismatched++; $display("FAIL rstmid_full_bus: got r=%h i=%h want 0", out_r, out_i); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_release: got %0b want 1", in_ready); end
        $display("test_reset_mid done");
    endtask

    // Right after reset; x0 is sent with in_first=0 and must not raise sync_err.
    task automatic test_extremes;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                compared++; if (sync_err !== 1'b0) begin mismatched++; $display("FAIL ext_sync_err k=%0d: got %0b want 0", k, sync_err); end
            end
            if (k % 2 == 0) drive(1'b1, 8'h80, 8'h7F, 1'b0);
            else            drive(1'b1, 8'h7F, 8'h80, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL ext_valid: got %0b want 1", out_valid); end
        compared++; if (out_r !== 64'h7F7F7F7F80808080) begin mismatched++; $display("FAIL ext_out_r: got %h want 7f7f7f7f80808080", out_r); end
        compared++; if (out_i !== 64'h808080807F7F7F7F) begin mismatched++; $display("FAIL ext_out_i: got %h want 808080807f7f7f7f", out_i); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL ext_consume: got vld=%0b rdy=%0b want 0 1", out_valid, in_ready); end
        $display("test_extremes done");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_resync();
        test_gapped();
        test_reset_mid();
        test_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
